// File: rtl/math_computer_arb_pkg.sv
// rtl/math_computer_arb_pkg.sv - shared types and sizing for the math computer arbiter
`ifndef DATASIZE
`define DATASIZE 8
`endif

package math_computer_arb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RES = 2'd2,
        DELIVER  = 2'd3
    } state_t;

    localparam int NREQ         = 2;
    localparam int DATASIZE_DEF = `DATASIZE;
    localparam int RES_W        = DATASIZE_DEF + 1;

    // Result carries the adder carry-out, so it is one bit wider than an operand.
    function automatic int res_w(input int datasize);
        return datasize + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin grant: pointer wins if requesting, else the other
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       pointer,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (req[pointer]) begin
            grant[pointer] = 1'b1;
        end else if (req[~pointer]) begin
            grant[~pointer] = 1'b1;
        end
    end

endmodule

// File: rtl/math_computer_arbiter.sv
// rtl/math_computer_arbiter.sv - shares one math computer between two requesters, one op in flight
`ifndef DATASIZE
`define DATASIZE 8
`endif

module math_computer_arbiter
    import math_computer_arb_pkg::*;
#(
    parameter int DATASIZE = `DATASIZE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [2*DATASIZE-1:0] req_a,
    input  logic [2*DATASIZE-1:0] req_b,
    input  logic [2*DATASIZE-1:0] req_c,
    output logic [1:0]            rsp_valid,
    input  logic [1:0]            rsp_ready,
    output logic [DATASIZE:0]     rsp_result,
    output logic                  mc_valid,
    input  logic                  mc_ready,
    output logic [DATASIZE-1:0]   mc_a,
    output logic [DATASIZE-1:0]   mc_b,
    output logic [DATASIZE-1:0]   mc_c,
    input  logic                  mc_res_valid,
    output logic                  mc_res_ready,
    input  logic [DATASIZE:0]     mc_result,
    output logic                  busy
);

    localparam int RW = res_w(DATASIZE);

    state_t              state_q, state_d;
    logic                ptr_q, ptr_d;
    logic                owner_q, owner_d;
    logic [DATASIZE-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
    logic [RW-1:0]       res_q, res_d;
    logic [1:0]          grant;

    rr_arbiter2 u_arb (
        .req     (req_valid),
        .pointer (ptr_q),
        .grant   (grant)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        res_d   = res_q;
        case (state_q)
            IDLE: begin
                if (grant != 2'b00) begin
                    owner_d = grant[1];
                    a_d     = grant[1] ? req_a[DATASIZE +: DATASIZE] : req_a[0 +: DATASIZE];
                    b_d     = grant[1] ? req_b[DATASIZE +: DATASIZE] : req_b[0 +: DATASIZE];
                    c_d     = grant[1] ? req_c[DATASIZE +: DATASIZE] : req_c[0 +: DATASIZE];
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (mc_ready) state_d = WAIT_RES;
            end
            WAIT_RES: begin
                if (mc_res_valid) begin
                    res_d   = mc_result;
                    state_d = DELIVER;
                end
            end
            DELIVER: begin
                if (rsp_ready[owner_q]) begin
                    ptr_d   = ~owner_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            owner_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            res_q   <= res_d;
        end
    end

    // req_ready is the only output fed straight from inputs, so it alone needs the reset gate.
    assign req_ready    = (state_q == IDLE && !rst) ? grant : 2'b00;
    assign mc_valid     = (state_q == ISSUE);
    assign mc_res_ready = (state_q == WAIT_RES);
    assign busy         = (state_q != IDLE);
    assign rsp_valid    = (state_q == DELIVER) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_result   = (state_q == DELIVER) ? res_q : '0;
    assign mc_a         = a_q;
    assign mc_b         = b_q;
    assign mc_c         = c_q;

endmodule

// File: tb/tb_math_computer_arbiter.sv
// tb/tb_math_computer_arbiter.sv - self-checking bench for math_computer_arbiter
module tb_math_computer_arbiter;

    logic        clk;
    logic        rst;
    logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
    logic [15:0] req_a, req_b, req_c;
    logic [8:0]  rsp_result, mc_result;
    logic        mc_valid, mc_ready, mc_res_valid, mc_res_ready, busy;
    logic [7:0]  mc_a, mc_b, mc_c;

    int tests = 0;
    int fails = 0;
    int ptr_m = 0;

    bit       mc_stall = 1'b0;
    bit       mc_hold  = 1'b0;
    bit       pend     = 1'b0;
    bit       resp     = 1'b0;
    logic [8:0] res_m  = '0;
    int       lat      = 0;

    math_computer_arbiter #(.DATASIZE(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_c        (req_c),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .mc_valid     (mc_valid),
        .mc_ready     (mc_ready),
        .mc_a         (mc_a),
        .mc_b         (mc_b),
        .mc_c         (mc_c),
        .mc_res_valid (mc_res_valid),
        .mc_res_ready (mc_res_ready),
        .mc_result    (mc_result),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Math computer: sums its three operands, one op at a time, random latency.
    initial begin
        mc_ready = 1'b0; mc_res_valid = 1'b0; mc_result = '0;
        forever begin
            @(posedge clk);
            if (rst) begin
                pend = 1'b0; resp = 1'b0;
            end else begin
                if (mc_res_valid && mc_res_ready) resp = 1'b0;
                if (mc_valid && mc_ready) begin
                    pend  = 1'b1;
                    res_m = 9'(mc_a) + 9'(mc_b) + 9'(mc_c);
                    lat   = $urandom_range(0, 3);
                end
            end
            @(negedge clk);
            if (rst) begin
                mc_ready = 1'b0; mc_res_valid = 1'b0; mc_result = '0;
            end else begin
                if (pend && !resp && !mc_hold) begin
                    if (lat == 0) begin
                        resp = 1'b1; pend = 1'b0;
                    end else begin
                        lat = lat - 1;
                    end
                end
                mc_res_valid = resp;
                mc_result    = resp ? res_m : 9'd0;
                mc_ready     = !pend && !resp && !mc_stall && ($urandom_range(0, 3) != 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic all_zero(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
        chk({tag, "_rsp_result"}, 32'(rsp_result), 0);
        chk({tag, "_mc_valid"}, 32'(mc_valid), 0);
        chk({tag, "_mc_res_ready"}, 32'(mc_res_ready), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
    endtask

    task automatic set_ops(input int idx, input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        req_a[idx*8 +: 8] = a;
        req_b[idx*8 +: 8] = b;
        req_c[idx*8 +: 8] = c;
    endtask

    task automatic issue(input int idx);
        int t;
        t = 0;
        #1;
        while (!req_ready[idx] && t < 50) begin
            @(negedge clk); #1; t++;
        end
        chk("req_ready_wait", 32'(req_ready[idx]), 1);
        @(posedge clk); #1;
        req_valid[idx] = 1'b0;
        @(negedge clk);
    endtask

    task automatic collect(input int idx, input logic [8:0] exp, input int stall);
        int t;
        t = 0;
        while (rsp_valid == 2'b00 && t < 50) begin
            @(negedge clk); t++;
        end
        chk("rsp_valid", 32'(rsp_valid), 32'(1 << idx));
        chk("rsp_result", 32'(rsp_result), 32'(exp));
        for (int s = 0; s < stall; s++) begin
            rsp_ready = 2'(1 << (1 - idx));
            @(negedge clk);
            chk("stall_rsp_valid", 32'(rsp_valid), 32'(1 << idx));
            chk("stall_rsp_result", 32'(rsp_result), 32'(exp));
            chk("stall_busy", 32'(busy), 1);
            chk("stall_req_ready", 32'(req_ready), 0);
        end
        rsp_ready = 2'(1 << idx);
        @(posedge clk); #1;
        rsp_ready = 2'b00;
        ptr_m = 1 - idx;
        @(negedge clk);
        chk("idle_after_rsp", 32'(busy), 0);
    endtask

    initial begin
        int t;
        rst = 1'b1; req_valid = 2'b11; rsp_ready = 2'b00;
        req_a = '0; req_b = '0; req_c = '0;
        set_ops(0, 8'd1, 8'd1, 8'd0);
        set_ops(1, 8'd10, 8'd20, 8'd0);
        repeat (2) @(negedge clk);
        #1;
        all_zero("reset");

        // Both requesting at reset exit: requester 0 first, then 1.
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("grant_at_reset_exit", 32'(req_ready), 32'(2'b01));
        issue(0);
        collect(0, 9'd2, 0);
        chk("second_grant", 32'(req_ready), 32'(2'b10));
        issue(1);
        collect(1, 9'd30, 0);

        set_ops(0, 8'd3, 8'd4, 8'd0);
        req_valid = 2'b01;
        issue(0);
        collect(0, 9'd7, 0);
        set_ops(0, 8'd5, 8'd5, 8'd5);
        set_ops(1, 8'd6, 8'd6, 8'd6);
        req_valid = 2'b11;
        #1;
        chk("pointer_after_req0", 32'(req_ready), 32'(2'b10));
        issue(1);
        req_valid = 2'b00;
        collect(1, 9'd18, 0);

        set_ops(1, 8'd255, 8'd255, 8'd0);
        req_valid = 2'b10;
        issue(1);
        collect(1, 9'h1FE, 0);

        // Owner holds off for 5 cycles while the other side asserts rsp_ready and req_valid.
        set_ops(0, 8'd100, 8'd50, 8'd25);
        req_valid = 2'b01;
        issue(0);
        set_ops(1, 8'd1, 8'd2, 8'd3);
        req_valid[1] = 1'b1;
        collect(0, 9'd175, 5);
        chk("grant_after_stall", 32'(req_ready), 32'(2'b10));
        issue(1);
        collect(1, 9'd6, 0);

        // Math computer back-pressure in ISSUE with the requester's inputs changing.
        mc_stall = 1'b1;
        @(negedge clk);
        set_ops(0, 8'h11, 8'h22, 8'h33);
        req_valid = 2'b01;
        issue(0);
        set_ops(0, 8'hAA, 8'hBB, 8'hCC);
        for (int i = 0; i < 4; i++) begin
            chk("issue_mc_valid", 32'(mc_valid), 1);
            chk("issue_mc_a", 32'(mc_a), 32'h11);
            chk("issue_mc_b", 32'(mc_b), 32'h22);
            chk("issue_mc_c", 32'(mc_c), 32'h33);
            @(negedge clk);
        end
        mc_stall = 1'b0;
        collect(0, 9'h066, 0);

        // Reset while waiting on the math computer.
        mc_hold = 1'b1;
        set_ops(0, 8'd9, 8'd9, 8'd9);
        req_valid = 2'b01;
        issue(0);
        t = 0;
        while (!mc_res_ready && t < 50) begin
            @(negedge clk); t++;
        end
        chk("reach_wait_res", 32'(mc_res_ready), 1);
        rst = 1'b1;
        #1;
        all_zero("async_rst");
        @(negedge clk);
        rst = 1'b0; mc_hold = 1'b0; ptr_m = 0;
        @(negedge clk);
        all_zero("post_rst");
        set_ops(0, 8'd2, 8'd3, 8'd4);
        req_valid = 2'b01;
        issue(0);
        collect(0, 9'd9, 0);

        // Random traffic against a round-robin reference.
        for (int n = 0; n < 24; n++) begin
            int idx, both, win;
            logic [7:0] a0, b0, c0, a1, b1, c1;
            logic [8:0] exp;
            idx  = $urandom_range(0, 1);
            both = $urandom_range(0, 1);
            a0 = 8'($urandom); b0 = 8'($urandom); c0 = 8'($urandom);
            a1 = 8'($urandom); b1 = 8'($urandom); c1 = 8'($urandom);
            set_ops(0, a0, b0, c0);
            set_ops(1, a1, b1, c1);
            req_valid = (both != 0) ? 2'b11 : 2'(1 << idx);
            win = (both != 0) ? ptr_m : idx;
            #1;
            chk("rand_grant", 32'(req_ready), 32'(1 << win));
            issue(win);
            req_valid = 2'b00;
            exp = (win != 0) ? (9'(a1) + 9'(b1) + 9'(c1)) : (9'(a0) + 9'(b0) + 9'(c0));
            collect(win, exp, $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
